// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), one full-subtractor cell reused LSB first.
// Optional macro SERSUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy,
   output logic             done
`ifdef SERSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   aSh_q, aSh_d;
   logic [WIDTH-1:0]   bSh_q, bSh_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               borrow_q, borrow_d;
   logic               bout_q, bout_d;
   logic               cellDiff, cellBout;
   logic               lastBit;
   logic               accept;
`ifdef SERSUB_OVF_EN
   logic               aMsb_q, aMsb_d;
   logic               bMsb_q, bMsb_d;
   logic               ovf_q, ovf_d;
`endif

   // The single shared full-subtractor cell, fed from the shift-register LSBs.
   always_comb begin
      cellDiff = aSh_q[0] ^ bSh_q[0] ^ borrow_q;
      cellBout = (~aSh_q[0] & bSh_q[0]) | (~(aSh_q[0] ^ bSh_q[0]) & borrow_q);
   end

   assign lastBit = (cnt_q == CNT_W'(WIDTH - 1));
   assign accept  = (state_q == IDLE) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (lastBit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // Datapath next state: capture on accept, one bit per RUN cycle, results frozen otherwise.
   always_comb begin
      aSh_d    = aSh_q;
      bSh_d    = bSh_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
`ifdef SERSUB_OVF_EN
      aMsb_d   = aMsb_q;
      bMsb_d   = bMsb_q;
      ovf_d    = ovf_q;
`endif
      if (accept) begin
         aSh_d    = a;
         bSh_d    = b;
         borrow_d = bin;
         cnt_d    = '0;
`ifdef SERSUB_OVF_EN
         aMsb_d   = a[WIDTH-1];
         bMsb_d   = b[WIDTH-1];
         ovf_d    = 1'b0;
`endif
      end else if (state_q == RUN) begin
         aSh_d    = {1'b0, aSh_q[WIDTH-1:1]};
         bSh_d    = {1'b0, bSh_q[WIDTH-1:1]};
         diff_d   = {cellDiff, diff_q[WIDTH-1:1]};
         borrow_d = cellBout;
         cnt_d    = cnt_q + CNT_W'(1);
         if (lastBit) begin
            bout_d = cellBout;
`ifdef SERSUB_OVF_EN
            // cellDiff is the result MSB arriving on this final edge.
            ovf_d  = (aMsb_q != bMsb_q) && (cellDiff != aMsb_q);
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aSh_q    <= '0;
         bSh_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
`ifdef SERSUB_OVF_EN
         aMsb_q   <= 1'b0;
         bMsb_q   <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         aSh_q    <= aSh_d;
         bSh_q    <= bSh_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
`ifdef SERSUB_OVF_EN
         aMsb_q   <= aMsb_d;
         bMsb_q   <= bMsb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERSUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
